// File: rtl/acc_pkg.sv
// Shared accelerator types and constants for the IFM input path.
package acc_pkg;
  localparam int IFM_DATA_WIDTH  = 512;
  localparam int PARSE_WIDTH     = 64;
  localparam int SLICES_PER_WORD = IFM_DATA_WIDTH / PARSE_WIDTH;

  typedef struct packed {
    logic                      last;
    logic [IFM_DATA_WIDTH-1:0] data;
  } ifm_entry_t;
endpackage

// File: rtl/sync_fifo_core.sv
// Circular FIFO storage with read/write pointers and an occupancy count.
// Full and empty are decided only from the count, never from pointer equality.
module sync_fifo_core #(
  parameter int W     = 513,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clear,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_wdata,
  output logic [W-1:0] o_head,
  output logic [AW:0]  o_count
);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  // Storage has no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (i_push && !i_clear) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
endmodule

// File: rtl/ifm_word_buffer.sv
// AXIS-fed word buffer in front of the IFM chunk parser; pops on the parser's last slice.
// Optional beat/backpressure statistics are built when IFM_WORD_BUF_STATS_EN is defined.
module ifm_word_buffer
  import acc_pkg::*;
#(
  parameter int DATA_WIDTH = IFM_DATA_WIDTH,
  parameter int DEPTH      = 4,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  conv_start,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] fm,
  output logic                  fm_valid,
  output logic                  fm_last,
  input  logic                  input_req,
  input  logic                  ifm_read,
  input  logic                  stall,
  output logic                  frame_done,
  output logic                  underflow
`ifdef IFM_WORD_BUF_STATS_EN
 ,output logic [31:0]           beat_cnt,
  output logic [31:0]           full_stall_cycles
`endif
);
  logic [DATA_WIDTH:0] w_head;
  logic [AW:0]         w_count;
  logic                w_empty;
  logic                w_push;
  logic                w_pop_req;
  logic                w_pop;
  logic                r_frame_done;
  logic                r_underflow;

  assign w_empty   = (w_count == '0);
  // No full-bypass: a full FIFO refuses a beat even while popping.
  assign s_axis_tready = ~rst & ~conv_start & (w_count != (AW+1)'(DEPTH));
  assign w_push    = s_axis_tvalid & s_axis_tready;
  assign w_pop_req = input_req & ifm_read & ~stall;
  assign w_pop     = w_pop_req & ~w_empty;

  sync_fifo_core #(
    .W     (DATA_WIDTH + 1),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .i_clear (conv_start),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata ({s_axis_tlast, s_axis_tdata}),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign fm       = w_empty ? '0 : w_head[DATA_WIDTH-1:0];
  assign fm_last  = ~w_empty & w_head[DATA_WIDTH];
  assign fm_valid = ~w_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_done <= 1'b0;
      r_underflow  <= 1'b0;
    end else if (conv_start) begin
      r_frame_done <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      r_frame_done <= w_pop & fm_last;
      if (w_pop_req && w_empty) r_underflow <= 1'b1;
    end
  end

  assign frame_done = r_frame_done;
  assign underflow  = r_underflow;

`ifdef IFM_WORD_BUF_STATS_EN
  logic [31:0] r_beat_cnt;
  logic [31:0] r_full_stall;

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat_cnt   <= '0;
      r_full_stall <= '0;
    end else if (conv_start) begin
      r_beat_cnt   <= '0;
      r_full_stall <= '0;
    end else begin
      if (w_push && r_beat_cnt != '1) r_beat_cnt <= r_beat_cnt + 32'd1;
      if (s_axis_tvalid && !s_axis_tready && r_full_stall != '1)
        r_full_stall <= r_full_stall + 32'd1;
    end
  end

  assign beat_cnt          = r_beat_cnt;
  assign full_stall_cycles = r_full_stall;
`endif
endmodule

// File: tb/tb_ifm_word_buffer.sv
// Bench for ifm_word_buffer: table-driven cycles against a queue scoreboard, plus async-reset sequence.
module tb_ifm_word_buffer;
  localparam int DW    = 512;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          conv_start;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tlast;
  logic          s_axis_tready;
  logic [DW-1:0] fm;
  logic          fm_valid;
  logic          fm_last;
  logic          input_req;
  logic          ifm_read;
  logic          stall;
  logic          frame_done;
  logic          underflow;
`ifdef IFM_WORD_BUF_STATS_EN
  logic [31:0]   beat_cnt;
  logic [31:0]   full_stall_cycles;
`endif

  always #5 clk = ~clk;

  ifm_word_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .conv_start    (conv_start),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .fm            (fm),
    .fm_valid      (fm_valid),
    .fm_last       (fm_last),
    .input_req     (input_req),
    .ifm_read      (ifm_read),
    .stall         (stall),
    .frame_done    (frame_done),
    .underflow     (underflow)
`ifdef IFM_WORD_BUF_STATS_EN
   ,.beat_cnt          (beat_cnt),
    .full_stall_cycles (full_stall_cycles)
`endif
  );

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } ent_t;

  typedef struct {
    logic v;
    int   tag;
    logic last;
    logic req;
    logic rd;
    logic st;
    logic cs;
    int   exp_cnt;
  } vec_t;

  ent_t q[$];
  vec_t vecs[$];
  logic m_uflow;
  int   n_err = 0;
  int   n_chk = 0;

  function automatic logic [DW-1:0] word(input int tag);
    logic [DW-1:0] w;
    for (int i = 0; i < DW/32; i++) w[i*32 +: 32] = 32'(tag * 16 + i) ^ 32'hA5A5_0000;
    return w;
  endfunction

  function automatic vec_t mkv(input logic v, input int tag, input logic last, input logic req,
                               input logic rd, input logic st, input logic cs, input int cnt);
    vec_t r;
    r.v = v; r.tag = tag; r.last = last; r.req = req; r.rd = rd; r.st = st; r.cs = cs;
    r.exp_cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, check head against scoreboard, clock, update scoreboard, check flags.
  task automatic cyc(input logic v, input int tag, input logic last, input logic req,
                     input logic rd, input logic st, input logic cs);
    ent_t hd;
    logic m_push, m_pop, m_preq, m_fd, m_uf_set;
    s_axis_tvalid = v;
    s_axis_tdata  = word(tag);
    s_axis_tlast  = last;
    input_req     = req;
    ifm_read      = rd;
    stall         = st;
    conv_start    = cs;
    #1;
    hd = (q.size() != 0) ? q[0] : '0;
    chk("tready", s_axis_tready, !cs && q.size() < DEPTH);
    chk("fm_valid", fm_valid, q.size() != 0);
    chk("fm", fm, hd.data);
    chk("fm_last", fm_last, hd.last);
    m_preq   = req && rd && !st;
    m_pop    = m_preq && q.size() != 0 && !cs;
    m_push   = v && !cs && q.size() < DEPTH;
    m_fd     = m_pop && hd.last;
    m_uf_set = m_preq && q.size() == 0;
    @(posedge clk);
    #1;
    if (cs) begin
      q.delete();
      m_uflow = 1'b0;
    end else begin
      if (m_pop) void'(q.pop_front());
      if (m_push) q.push_back({last, word(tag)});
      if (m_uf_set) m_uflow = 1'b1;
    end
    chk("frame_done", frame_done, m_fd);
    chk("underflow", underflow, m_uflow);
  endtask

  initial begin
    rst = 1'b1; conv_start = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
    input_req = 1'b0; ifm_read = 1'b0; stall = 1'b0; m_uflow = 1'b0;

    //        v  tag last req rd st cs cnt
    vecs.push_back(mkv(1, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mkv(1, 1, 0, 0, 0, 0, 0, 2));
    vecs.push_back(mkv(1, 2, 0, 0, 0, 0, 0, 3));
    vecs.push_back(mkv(1, 3, 0, 0, 0, 0, 0, 4));
    vecs.push_back(mkv(1, 4, 0, 0, 0, 0, 0, 4));
    vecs.push_back(mkv(0, 0, 0, 1, 1, 0, 0, 3));
    vecs.push_back(mkv(1, 4, 0, 0, 0, 0, 0, 4));
    vecs.push_back(mkv(1, 5, 0, 1, 1, 0, 0, 3));
    vecs.push_back(mkv(1, 5, 0, 0, 0, 0, 0, 4));
    vecs.push_back(mkv(0, 0, 0, 1, 1, 1, 0, 4));
    vecs.push_back(mkv(0, 0, 0, 1, 1, 0, 0, 3));
    vecs.push_back(mkv(0, 0, 0, 1, 1, 0, 0, 2));
    vecs.push_back(mkv(0, 0, 0, 1, 1, 0, 0, 1));
    vecs.push_back(mkv(1, 6, 0, 1, 1, 0, 0, 1));
    vecs.push_back(mkv(0, 0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mkv(1, 7, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mkv(1, 8, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mkv(1, 8, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mkv(1, 9, 0, 0, 0, 0, 0, 2));
    vecs.push_back(mkv(1, 10, 1, 0, 0, 0, 0, 3));
    vecs.push_back(mkv(0, 0, 0, 1, 1, 0, 0, 2));
    vecs.push_back(mkv(0, 0, 0, 1, 1, 0, 0, 1));
    vecs.push_back(mkv(0, 0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(1, 11, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mkv(1, 12, 0, 0, 0, 0, 0, 2));
    vecs.push_back(mkv(1, 13, 0, 0, 0, 0, 0, 3));
    vecs.push_back(mkv(0, 0, 0, 1, 1, 0, 1, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(1, 14, 0, 1, 1, 1, 0, 1));
    vecs.push_back(mkv(0, 0, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mkv(0, 0, 0, 0, 1, 0, 0, 1));

    #12;
    chk("rst_tready", s_axis_tready, 1'b0);
    chk("rst_fm_valid", fm_valid, 1'b0);
    chk("rst_fm", fm, '0);
    chk("rst_fm_last", fm_last, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_underflow", underflow, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].v, vecs[i].tag, vecs[i].last, vecs[i].req, vecs[i].rd, vecs[i].st, vecs[i].cs);
      chk($sformatf("count[%0d]", i), DW'(dut.w_count), DW'(vecs[i].exp_cnt));
    end

    // Set underflow, refill mid-frame, then assert reset between clock edges.
    cyc(0, 0, 0, 1, 1, 0, 0);
    cyc(0, 0, 0, 1, 1, 0, 0);
    cyc(1, 15, 0, 0, 0, 0, 0);
    cyc(1, 16, 0, 0, 0, 0, 0);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = word(17);
    input_req     = 1'b0;
    ifm_read      = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk("arst_tready", s_axis_tready, 1'b0);
    chk("arst_fm_valid", fm_valid, 1'b0);
    chk("arst_fm", fm, '0);
    chk("arst_fm_last", fm_last, 1'b0);
    chk("arst_underflow", underflow, 1'b0);
    chk("arst_frame_done", frame_done, 1'b0);
    @(posedge clk);
    #1;
    chk("arst_hold_fm_valid", fm_valid, 1'b0);
    s_axis_tvalid = 1'b0;
    #2;
    rst = 1'b0;
    q.delete();
    m_uflow = 1'b0;
    @(posedge clk);
    #1;
    cyc(1, 20, 1, 0, 0, 0, 0);
    chk("post_rst_fm", fm, word(20));
    cyc(0, 0, 0, 1, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
